// File: rtl/mul3_serial_sched_if.sv
// Bundle of the scheduler's client-side and serial-unit-side signals.
//   req/req_data   : requester operands (level request, held until granted)
//   gnt            : one-hot, one-cycle grant pulse
//   rsp_*          : valid/ready response with W+2-bit product and requester id
//   ser_clr_n/ser_data/ser_out : link to the shared bit-serial x3 unit
// Modports: slave = scheduler view, master = client/environment view.
interface mul3_serial_sched_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 8
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W+1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              ser_clr_n;
  logic              ser_data;
  logic              ser_out;

  modport slave (
    input  req, req_data, rsp_ready, ser_out,
    output gnt, rsp_valid, rsp_data, rsp_id, ser_clr_n, ser_data
  );

  modport master (
    output req, req_data, rsp_ready, ser_out,
    input  gnt, rsp_valid, rsp_data, rsp_id, ser_clr_n, ser_data
  );
endinterface

// File: rtl/mul3_serial_sched.sv
// Round-robin scheduler sharing one bit-serial multiply-by-3 unit among NREQ
// requesters. A granted operand is sent LSB-first after a one-cycle clear of the
// serial unit; the serial product is collected and returned as a W+2-bit word.
// Ports:
//   clk     : clock, posedge
//   reset   : asynchronous, active-low
//   bus     : mul3_serial_sched_if.slave (requests, grants, response, serial link)
//   chk_err : sticky product-check error (only with MUL3_SCHED_CHECK_EN defined)
// Optional feature macro: MUL3_SCHED_CHECK_EN adds a parallel x3 comparator.
module mul3_serial_sched #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 8
) (
  input logic                clk,
  input logic                reset,
  mul3_serial_sched_if.slave bus
`ifdef MUL3_SCHED_CHECK_EN
  ,
  output logic               chk_err
`endif
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned KW  = $clog2(W + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      r_state, w_state_d;
  logic [IDW-1:0]  r_ptr, r_id, w_pick;
  logic            w_any, w_hit_hi;
  logic [W-1:0]    r_op, w_sel;
  logic [KW-1:0]   r_k, w_k_d;
  logic [W+1:0]    r_prod, w_prod_shift;
  logic            r_ser_clr_n, r_ser_data, w_ser_data_d;
  logic            w_grant;

  // Round robin: lowest requester above the pointer wins, otherwise wrap to the
  // lowest requester at or below it.
  always_comb begin
    w_any    = |bus.req;
    w_hit_hi = 1'b0;
    w_pick   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (i > int'(r_ptr))) begin
        w_hit_hi = 1'b1;
        w_pick   = IDW'(i);
      end
    end
    if (!w_hit_hi) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (bus.req[i]) w_pick = IDW'(i);
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IDW'(i)) w_sel = bus.req_data[i*W +: W];
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_any;

  // Reset gates the grant so gnt reads zero while reset is held.
  always_comb begin
    bus.gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant && reset && (w_pick == IDW'(i))) bus.gnt[i] = 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    case (r_state)
      S_IDLE:  if (w_any) w_state_d = S_CLEAR;
      S_CLEAR: begin
        w_state_d = S_SHIFT;
        w_k_d     = '0;
      end
      S_SHIFT: begin
        if (r_k == KW'(W + 1)) w_state_d = S_DRAIN;
        else                   w_k_d     = r_k + 1'b1;
      end
      S_DRAIN: w_state_d = S_DONE;
      S_DONE:  if (bus.rsp_ready) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  // Serial outputs are registered: compute the value for the next cycle's state/k.
  always_comb begin
    w_ser_data_d = 1'b0;
    if (w_state_d == S_SHIFT) begin
      for (int unsigned b = 0; b < W; b++) begin
        if (w_k_d == KW'(b)) w_ser_data_d = r_op[b];
      end
    end
  end

  // Product bits arrive LSB first; shifting in from the top leaves bit 0 at [0]
  // after W+2 captures (SHIFT k=1..W+1 plus DRAIN).
  assign w_prod_shift = {bus.ser_out, r_prod[W+1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_op        <= '0;
      r_k         <= '0;
      r_prod      <= '0;
      r_ser_clr_n <= 1'b0;
      r_ser_data  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_k         <= w_k_d;
      r_ser_clr_n <= (w_state_d != S_CLEAR);
      r_ser_data  <= w_ser_data_d;
      if (w_grant) begin
        r_ptr <= w_pick;
        r_id  <= w_pick;
        r_op  <= w_sel;
      end
      if (((r_state == S_SHIFT) && (r_k != '0)) || (r_state == S_DRAIN)) begin
        r_prod <= w_prod_shift;
      end
    end
  end

  assign bus.rsp_valid = (r_state == S_DONE);
  assign bus.rsp_data  = r_prod;
  assign bus.rsp_id    = r_id;
  assign bus.ser_clr_n = r_ser_clr_n;
  assign bus.ser_data  = r_ser_data;

`ifdef MUL3_SCHED_CHECK_EN
  logic [W+1:0] w_expect;
  logic         r_chk_err;

  assign w_expect = {2'b00, r_op} + {1'b0, r_op, 1'b0};

  // Compare at the DRAIN->DONE edge, using the product including its last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk_err <= 1'b0;
    end else if ((r_state == S_DRAIN) && (w_prod_shift != w_expect)) begin
      r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`endif
endmodule

// File: tb/tb_mul3_serial_sched.sv
// Self-checking bench for mul3_serial_sched: behavioural serial x3 unit, a
// transaction-level reference model checked every cycle, directed scenarios and
// a randomized request/ready phase.
module tb_mul3_serial_sched;
  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 8;
  localparam int          LAT  = W + 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul3_serial_sched_if #(.NREQ(NREQ), .W(W)) bus ();

`ifdef MUL3_SCHED_CHECK_EN
  logic chk_err;
`endif

  mul3_serial_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus)
`ifdef MUL3_SCHED_CHECK_EN
    ,
    .chk_err(chk_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural serial x3 unit: out_k = x_k + x_{k-1} + carry, one cycle late.
  logic       su_prev  = 1'b0;
  logic       su_c     = 1'b0;
  logic       su_out   = 1'b0;
  logic       su_first = 1'b0;
  logic       flip0    = 1'b0;
  logic [1:0] su_sum;
  assign su_sum      = {1'b0, bus.ser_data} + {1'b0, su_prev} + {1'b0, su_c};
  assign bus.ser_out = su_out;

  always @(posedge clk) begin
    if (!bus.ser_clr_n) begin
      su_prev  <= 1'b0;
      su_c     <= 1'b0;
      su_out   <= 1'b0;
      su_first <= 1'b1;
    end else begin
      su_out   <= su_sum[0] ^ (su_first & flip0);
      su_c     <= su_sum[1];
      su_prev  <= bus.ser_data;
      su_first <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one operation at a time, round-robin from ptr+1, response
  // due LAT cycles after grant and held until accepted.
  bit              m_busy = 1'b0;
  int              m_ptr  = NREQ - 1;
  int              m_id, m_data, m_due, m_j;
  logic [NREQ-1:0] m_exp_gnt;
  logic [NREQ-1:0] last_gnt = '0;

  always @(negedge clk) begin
    if (!reset) begin
      m_busy   = 1'b0;
      m_ptr    = NREQ - 1;
      last_gnt = '0;
    end else begin
      if (!m_busy) begin
        m_exp_gnt = '0;
        for (int s = 1; s <= NREQ; s++) begin
          m_j = (m_ptr + s) % NREQ;
          if (m_exp_gnt == '0 && bus.req[m_j]) begin
            m_exp_gnt[m_j] = 1'b1;
            m_id   = m_j;
            m_data = (3 * int'(bus.req_data[m_j*W +: W])) ^ int'(flip0);
            m_due  = cyc + LAT;
          end
        end
        check("gnt", bus.gnt, m_exp_gnt);
        check("rsp_valid_idle", bus.rsp_valid, 0);
        if (m_exp_gnt != '0) begin
          m_ptr  = m_id;
          m_busy = 1'b1;
        end
      end else begin
        check("gnt_busy", bus.gnt, 0);
        check("rsp_valid", bus.rsp_valid, (cyc >= m_due) ? 1 : 0);
        if (cyc >= m_due) begin
          check("rsp_data", bus.rsp_data, m_data);
          check("rsp_id", bus.rsp_id, m_id);
          if (bus.rsp_ready) m_busy = 1'b0;
        end
      end
      last_gnt = bus.gnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int i, output int at);
    at = -1;
    for (int n = 0; n < 100 && at < 0; n++) begin
      @(negedge clk);
      if (bus.gnt[i]) at = cyc;
    end
    if (at < 0) check("gnt_timeout", 32'(bus.gnt[i]), 1);
  endtask

  task automatic wait_any_gnt(output int at, output logic [NREQ-1:0] who);
    at  = -1;
    who = '0;
    for (int n = 0; n < 100 && at < 0; n++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        at  = cyc;
        who = bus.gnt;
      end
    end
    if (at < 0) check("gnt_any_timeout", 32'(bus.gnt != '0), 1);
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int n = 0; n < 100 && at < 0; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) at = cyc;
    end
    if (at < 0) check("rsp_timeout", 32'(bus.rsp_valid), 1);
  endtask

  task automatic request(input int i, input int data, output int at);
    tick();
    bus.req[i]              = 1'b1;
    bus.req_data[i*W +: W]  = W'(data);
    wait_gnt(i, at);
    tick();
    bus.req[i] = 1'b0;
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_gnt"}, bus.gnt, 0);
    check({t, "_rsp_valid"}, bus.rsp_valid, 0);
    check({t, "_rsp_data"}, bus.rsp_data, 0);
    check({t, "_rsp_id"}, bus.rsp_id, 0);
    check({t, "_ser_clr_n"}, bus.ser_clr_n, 0);
    check({t, "_ser_data"}, bus.ser_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r, prev;
    logic [NREQ-1:0] who;
    logic [9:0]      seq;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    #1 reset = 1'b0;
    #1 check_reset_vals("por");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) tick();

    // Single operation, latency and value.
    request(0, 5, g);
    wait_rsp(r);
    check("t1_latency", r - g, LAT);
    check("t1_data", bus.rsp_data, 15);
    check("t1_id", bus.rsp_id, 0);
    repeat (3) tick();

    // Max operand and serial bit sequence after CLEAR.
    seq = 10'b00_1111_1111;
    request(1, 255, g);
    @(negedge clk);
    check("t2_clear_clr_n", bus.ser_clr_n, 0);
    check("t2_clear_data", bus.ser_data, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t2_ser_data", bus.ser_data, seq[k]);
      check("t2_ser_clr_n", bus.ser_clr_n, 1);
    end
    wait_rsp(r);
    check("t2_data", bus.rsp_data, 765);
    check("t2_id", bus.rsp_id, 1);
    repeat (3) tick();

    // Both requesters held: alternate grants, W+6 spacing.
    bus.req_data[0 +: W] = W'(3);
    bus.req_data[W +: W] = W'(4);
    bus.req = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any_gnt(g, who);
      check("t3_order", who, (k % 2 == 0) ? 1 : 2);
      if (k > 0) check("t3_gap", g - prev, W + 6);
      prev = g;
    end
    tick();
    bus.req = '0;
    repeat (20) tick();

    // Backpressure: response held, no grant until handshake.
    bus.rsp_ready = 1'b0;
    bus.req[0] = 1'b1;
    bus.req_data[0 +: W] = W'(100);
    wait_gnt(0, g);
    tick();
    bus.req[0] = 1'b0;
    bus.req[1] = 1'b1;
    bus.req_data[W +: W] = W'(9);
    wait_rsp(r);
    check("t4_data", bus.rsp_data, 300);
    check("t4_id", bus.rsp_id, 0);
    repeat (5) @(negedge clk);
    check("t4_held_valid", bus.rsp_valid, 1);
    check("t4_held_data", bus.rsp_data, 300);
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_valid_drop", bus.rsp_valid, 0);
    check("t4_next_gnt", bus.gnt, 2);
    tick();
    bus.req[1] = 1'b0;
    repeat (20) tick();

    // Reset during SHIFT k=4 discards the operation.
    request(0, 50, g);
    repeat (6) @(negedge clk);
    #1 reset = 1'b0;
    bus.req[1] = 1'b1;
    #1 check_reset_vals("t5");
    @(negedge clk);
    @(negedge clk);
    bus.req[1] = 1'b0;
    #2 reset = 1'b1;
    request(0, 7, g);
    wait_rsp(r);
    check("t5_latency", r - g, LAT);
    check("t5_data", bus.rsp_data, 21);
    check("t5_id", bus.rsp_id, 0);
    repeat (5) tick();

    // Randomized requests and backpressure against the model.
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt[i]) begin
          bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
          bus.req_data[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'(255) : W'($urandom);
        end else if (bus.req[i] && $urandom_range(0, 31) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
    end
    tick();
    bus.req       = '0;
    bus.rsp_ready = 1'b1;
    repeat (30) tick();

`ifdef MUL3_SCHED_CHECK_EN
    check("chk_clean", chk_err, 0);
    flip0 = 1'b1;
    request(0, 5, g);
    wait_rsp(r);
    check("chk_bad_data", bus.rsp_data, 14);
    check("chk_set", chk_err, 1);
    flip0 = 1'b0;
    tick();
    request(1, 4, g);
    wait_rsp(r);
    check("chk_good_data", bus.rsp_data, 12);
    check("chk_sticky", chk_err, 1);
    repeat (3) tick();
    reset = 1'b0;
    #1 check("chk_reset", chk_err, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul3_serial_sched.md
Name: mul3_serial_sched

Overview:
- Round-robin scheduler sharing one bit-serial multiply-by-3 unit among NREQ requesters.
- Grants one parallel operand at a time, clears the serial unit, and shifts the operand in LSB-first.
- Collects the serial product bits and returns a parallel W+2-bit product with the requester id over a valid/ready response port.
- Sits between parallel-word clients and the shared serial x3 datapath on the same clk.

Parameters:
- NREQ, 2, number of requesters (>=2).
- W, 8, operand width in bits (>=2).
- IDW, $clog2(NREQ), width of requester id (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low.
- req  in  NREQ  per-requester request; level, held until granted.
- req_data  in  NREQ*W  operands; requester i occupies bits [i*W +: W].
- gnt  out  NREQ  one-hot, one-cycle pulse; operand of the granted requester latched that cycle.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts product.
- rsp_data  out  W+2  operand*3.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- ser_clr_n  out  1  active-low clear to the serial unit; registered, glitch-free.
- ser_data  out  1  serial operand bit, LSB first; registered.
- ser_out  in  1  serial product bit from the unit; Moore: the bit for input k is valid in the cycle after ser_data carried bit k.

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, rsp_id=0, ser_clr_n=0 (holds the serial unit cleared), ser_data=0, RR pointer=NREQ-1, state=IDLE.
- IDLE: ser_clr_n=1. If any req is set, grant the first set bit searching upward from (ptr+1) mod NREQ with wrap.
  - Pulse gnt, latch the operand and id, set ptr=id, go to CLEAR. No req: stay in IDLE.
- CLEAR (1 cycle): ser_clr_n=0, ser_data=0. Bit counter k=0. Go to SHIFT.
- SHIFT (W+2 cycles, k=0..W+1): ser_clr_n=1. ser_data = operand[k] for k<W, 0 for k>=W.
  - For k>=1, capture ser_out as product bit k-1. Go to DRAIN when k=W+1.
- DRAIN (1 cycle): ser_data=0; capture ser_out as product bit W+1. Go to DONE.
- DONE: rsp_valid=1; rsp_data and rsp_id are stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid=0 next cycle, return to IDLE.
- Arbitration happens only in IDLE, so new grants wait until the response has been accepted. req deasserted before a grant is simply ignored.
- Latency: gnt in cycle g puts rsp_valid=1 in cycle g+W+5 (13 cycles for W=8). Minimum grant-to-grant spacing is W+6 cycles with rsp_ready tied high.
- Width: product bits at and above W+2 are not produced. (2^W-1)*3 fits in W+2 bits.
- gnt is only ever one-hot or zero. At most one operation is in flight.
- reset asserted mid-operation: immediate return to reset values, including ser_clr_n=0. The in-flight product is discarded and no rsp is issued for it.
- ser_out is ignored in IDLE, CLEAR and DONE.

Optional Feature:
- Macro MUL3_SCHED_CHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit, reset 0).
  - On entry to DONE, compares the captured product with operand*3 computed in parallel. Any mismatch sets chk_err sticky until reset.
- Undefined: no chk_err port and no comparator logic. Behaviour is otherwise identical.

Test Plan:
- W=8, req[0] with data 5, rsp_ready=1 -> gnt=01 for one cycle; rsp_valid 13 cycles later with rsp_data=15, rsp_id=0.
- req[1] with data 255 -> rsp_data=765 (10'h2FD), rsp_id=1. ser_data sequence after CLEAR: 1,1,1,1,1,1,1,1,0,0.
- req=11 held continuously, data0=3, data1=4 -> grant order 0,1,0,1; responses 9(id0), 12(id1), 9, 12; gnt spacing 14 cycles.
- Data 100, rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data=300 and rsp_id held stable; no gnt until the handshake; rsp_valid drops the cycle after ready=1.
- reset pulsed low during SHIFT k=4, then req[0] with data 7 -> outputs at reset values during reset; the next response is 21 only, with no stale response.
- MUL3_SCHED_CHECK_EN defined, serial model forced to flip product bit 0 -> chk_err=1 on entry to DONE and stays 1 across later correct operations until reset.
